// File: rtl/sqrt_iter_ctrl.sv
// Restoring digit-by-digit integer square root; one trial subtraction per cycle
// through an external combinational adder.
module sqrt_iter_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     radicand_i,
  output logic [WIDTH-1:0]     add_a_o,
  output logic [WIDTH-1:0]     add_b_o,
  output logic                 add_ci_o,
  input  logic [WIDTH-1:0]     add_s_i,
  input  logic                 add_co_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WIDTH/2-1:0]   root_o,
  output logic [WIDTH/2:0]     rem_o
);

  localparam int RW = WIDTH / 2;
  localparam int CW = $clog2(RW) + 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t            r_state, w_state_nx;
  logic [WIDTH-1:0]  r_rem, w_rem_nx;
  logic [WIDTH-1:0]  r_x, w_x_nx;
  logic [RW-1:0]     r_root, w_root_nx;
  logic [CW-1:0]     r_cnt, w_cnt_nx;
  logic              r_busy, w_busy_nx;
  logic              r_done, w_done_nx;
  logic [RW-1:0]     r_root_o, w_root_o_nx;
  logic [RW:0]       r_rem_o, w_rem_o_nx;

  logic [WIDTH-1:0]  w_rem_sh;
  logic [WIDTH-1:0]  w_trial;

  // Adder drive is purely from registers so it is stable in every state.
  always_comb begin
    w_rem_sh = {r_rem[WIDTH-3:0], r_x[WIDTH-1:WIDTH-2]};
    w_trial  = WIDTH'({r_root, 2'b01});
    add_a_o  = w_rem_sh;
    add_b_o  = ~w_trial;
    add_ci_o = 1'b1;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_rem_nx    = r_rem;
    w_x_nx      = r_x;
    w_root_nx   = r_root;
    w_cnt_nx    = r_cnt;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_root_o_nx = r_root_o;
    w_rem_o_nx  = r_rem_o;
    case (r_state)
      IDLE, DONE: begin
        w_state_nx = IDLE;
        if (start_i) begin
          w_x_nx     = radicand_i;
          w_rem_nx   = '0;
          w_root_nx  = '0;
          w_cnt_nx   = CW'(RW - 1);
          w_busy_nx  = 1'b1;
          w_state_nx = ITER;
        end
      end
      ITER: begin
        // Carry-out high means no borrow: the trial fits, so keep the difference.
        if (add_co_i) begin
          w_rem_nx  = add_s_i;
          w_root_nx = {r_root[RW-2:0], 1'b1};
        end else begin
          w_rem_nx  = w_rem_sh;
          w_root_nx = {r_root[RW-2:0], 1'b0};
        end
        w_x_nx   = r_x << 2;
        w_cnt_nx = r_cnt - CW'(1);
        if (r_cnt == '0) begin
          w_state_nx  = DONE;
          w_busy_nx   = 1'b0;
          w_done_nx   = 1'b1;
          w_root_o_nx = w_root_nx;
          w_rem_o_nx  = w_rem_nx[RW:0];
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_x      <= '0;
      r_root   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_root_o <= '0;
      r_rem_o  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_rem    <= w_rem_nx;
      r_x      <= w_x_nx;
      r_root   <= w_root_nx;
      r_cnt    <= w_cnt_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_root_o <= w_root_o_nx;
      r_rem_o  <= w_rem_o_nx;
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign root_o = r_root_o;
  assign rem_o  = r_rem_o;

endmodule

// File: tb/tb_sqrt_iter_ctrl.sv
// Directed bench for sqrt_iter_ctrl with a behavioural 16-bit adder on add_*.
module tb_sqrt_iter_ctrl;

  localparam int WIDTH = 16;
  localparam int RW    = WIDTH / 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  radicand;
  logic [WIDTH-1:0]  add_a, add_b, add_s;
  logic              add_ci, add_co;
  logic              busy, done;
  logic [RW-1:0]     root;
  logic [RW:0]       rem;

  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] last_root;
  logic [RW:0]   last_rem;

  sqrt_iter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .radicand_i (radicand),
    .add_a_o    (add_a),
    .add_b_o    (add_b),
    .add_ci_o   (add_ci),
    .add_s_i    (add_s),
    .add_co_i   (add_co),
    .busy_o     (busy),
    .done_o     (done),
    .root_o     (root),
    .rem_o      (rem)
  );

  // Stand-in for the external carry-lookahead adder: {Co,S} = A + B + Ci.
  always_comb {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation: start accepted at edge k, done expected exactly at edge k+RW.
  task automatic do_op(input logic [WIDTH-1:0] rad, input logic [RW-1:0] exp_root,
                       input logic [RW:0] exp_rem, input string tag);
    @(negedge clk);
    start    = 1'b1;
    radicand = rad;
    @(posedge clk);
    #1;
    start    = 1'b0;
    radicand = ~rad;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_root_hold"}, 32'(root), 32'(last_root));
    check({tag, "_rem_hold"}, 32'(rem), 32'(last_rem));
    repeat (RW - 1) @(posedge clk);
    #1;
    check({tag, "_no_early_done"}, 32'(done), 32'd0);
    check({tag, "_busy_late"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_root"}, 32'(root), 32'(exp_root));
    check({tag, "_rem"}, 32'(rem), 32'(exp_rem));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    last_root = exp_root;
    last_rem  = exp_rem;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    radicand = '0;
    last_root = '0;
    last_rem  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_root", 32'(root), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("adder_ci", 32'(add_ci), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'h0000, 8'd0,   9'd0,   "r0");
    do_op(16'hFFFF, 8'd255, 9'd510, "rffff");
    do_op(16'd144,  8'd12,  9'd0,   "r144");
    do_op(16'd200,  8'd14,  9'd4,   "r200");
    do_op(16'd1,    8'd1,   9'd0,   "r1");
    do_op(16'd2,    8'd1,   9'd1,   "r2");
    do_op(16'd15,   8'd3,   9'd6,   "r15");
    do_op(16'h4000, 8'd128, 9'd0,   "r4000");
    do_op(16'hFFFE, 8'd255, 9'd509, "rfffe");

    // start held high: first start takes 200, the DONE-cycle restart takes 50.
    @(negedge clk);
    start    = 1'b1;
    radicand = 16'd200;
    @(posedge clk);
    #1;
    radicand = 16'd50;
    check("bb_busy0", 32'(busy), 32'd1);
    repeat (RW - 1) @(posedge clk);
    #1;
    check("bb_no_early", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("bb_done1", 32'(done), 32'd1);
    check("bb_root1", 32'(root), 32'd14);
    check("bb_rem1", 32'(rem), 32'd4);
    @(posedge clk);
    #1;
    check("bb_restart_busy", 32'(busy), 32'd1);
    check("bb_restart_done", 32'(done), 32'd0);
    check("bb_hold_root", 32'(root), 32'd14);
    repeat (RW - 1) @(posedge clk);
    #1;
    check("bb_no_early2", 32'(done), 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("bb_done2", 32'(done), 32'd1);
    check("bb_root2", 32'(root), 32'd7);
    check("bb_rem2", 32'(rem), 32'd1);
    @(posedge clk);
    #1;
    check("bb_done2_pulse", 32'(done), 32'd0);
    check("bb_idle_busy", 32'(busy), 32'd0);
    last_root = 8'd7;
    last_rem  = 9'd1;

    // Asynchronous reset in the middle of a computation.
    @(negedge clk);
    start    = 1'b1;
    radicand = 16'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_root", 32'(root), 32'd0);
    check("abort_rem", 32'(rem), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 2 * RW; i++) begin
        @(posedge clk);
        #1;
        if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      check("abort_no_done", 32'(seen), 32'd0);
    end
    last_root = '0;
    last_rem  = '0;
    do_op(16'd81, 8'd9, 9'd0, "r81");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sqrt_iter_ctrl.md
Name: sqrt_iter_ctrl

Overview:
- Sequential digit-by-digit (restoring) integer square-root controller for a WIDTH-bit unsigned radicand.
- Sits directly upstream of the 16-bit two-stage carry-lookahead adder. It drives that adder's operand and carry-in pins and consumes its sum and carry-out to make one trial subtraction per cycle.
- Produces the WIDTH/2-bit root and the remainder after WIDTH/2 iterations.

Parameters:
- WIDTH, 16, radicand and adder width. Must be even and >= 4. Root width is RW = WIDTH/2.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only when not busy.
- radicand_i  in  WIDTH  unsigned operand; captured on an accepted start.
- add_a_o  out  WIDTH  to adder A_i: partial remainder after shift.
- add_b_o  out  WIDTH  to adder B_i: bitwise inverse of the trial value.
- add_ci_o  out  1  to adder Ci_i: constant 1, so the adder computes A - trial.
- add_s_i  in  WIDTH  from adder S_o: difference.
- add_co_i  in  1  from adder Co_o: 1 means no borrow (A >= trial).
- busy_o  out  1  high while the computation is in progress.
- done_o  out  1  one-cycle pulse when the result becomes valid.
- root_o  out  RW  floor(sqrt(radicand)).
- rem_o  out  RW+1  radicand - root^2.

Behaviour:
Reset (async, rst_i=1):
- State goes to IDLE.
- busy_o=0, done_o=0, root_o=0, rem_o=0.
- Internal regs cleared: rem_r (WIDTH), x_r (WIDTH), root_r (RW), cnt (log2(RW)+1).
- Reset asserted mid-computation aborts it. No done_o pulse follows.

State machine: IDLE, ITER, DONE.
- IDLE, start_i=1 at edge k:
  - x_r <= radicand_i; rem_r <= 0; root_r <= 0; cnt <= RW-1.
  - Go to ITER; busy_o <= 1.
- ITER, each edge performs one step:
  - Combinational: rem_sh = {rem_r[WIDTH-3:0], x_r[WIDTH-1:WIDTH-2]}; trial = {root_r, 2'b01}, zero-extended to WIDTH.
  - Adder drive: add_a_o = rem_sh, add_b_o = ~trial, add_ci_o = 1.
  - add_co_i=1: rem_r <= add_s_i; root_r <= {root_r[RW-2:0], 1}.
  - add_co_i=0: rem_r <= rem_sh; root_r <= {root_r[RW-2:0], 0}.
  - x_r <= x_r << 2; cnt <= cnt-1.
  - When cnt==0: go to DONE; busy_o <= 0; done_o <= 1.
  - root_o/rem_o <= the final root_r/rem_r next values, i.e. the values written on this edge.
- DONE: lasts one cycle, then IDLE.
  - done_o returns to 0.
  - start_i=1 in DONE is accepted exactly as in IDLE (back-to-back operation).
- Latency: start accepted at edge k; done_o high from edge k+RW (k+8 at default) for exactly one cycle.
- Throughput: one result per RW+1 cycles.

Handshake and output rules:
- start_i while busy_o=1 is ignored; radicand_i changes during ITER have no effect.
- root_o/rem_o hold their last result until the next completion. They do not change at start.
- add_* outputs are combinational from registers and valid in every state. The adder result is used only in ITER.
- Widths: rem_r never exceeds 2*root+... < 2^(RW+2), so no overflow in WIDTH bits. rem_o = rem_r[RW:0].
- The adder is external and purely combinational; its path is single-cycle within clk_i.

Test Plan:
- radicand 0x0000 -> done_o at start+8, root_o=0, rem_o=0; busy_o high 8 cycles.
- radicand 0xFFFF -> root_o=255 (0xFF), rem_o=510 (0x1FE). radicand 144 -> root_o=12, rem_o=0. radicand 200 -> root_o=14, rem_o=4.
- start_i held high for 20 cycles with radicand 200 then 50 -> result 14/4 from the first start. Second start accepted in the DONE cycle -> root_o=7, rem_o=1, done_o at next start+8.
- rst_i pulsed asynchronously at iteration 4 of radicand 65535 -> all outputs 0 immediately, no done_o. A fresh start with 81 -> root_o=9, rem_o=0.
- Exhaustive 0..65535 with the real CLA2x8 hooked to add_* -> root^2+rem==radicand and rem<=2*root for every value; done_o exactly one cycle each.
